// File: rtl/panel_entry_ctrl.sv
// Front-panel command sequencer: hex entry, panel address, memory and CPU-register handshakes.
// Optional `PANEL_AUTOREAD_EN adds a READ of addr after load, dec and a completed store.
`timescale 1ns/1ps

module panel_entry_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       key_hex,
  input  logic              key_load,
  input  logic              key_storeinc,
  input  logic              key_dec,
  input  logic [4:0]        key_reg,
  output logic [ADDR_W-1:0] entry,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              reg_req,
  output logic [2:0]        reg_sel,
  output logic [ADDR_W-1:0] reg_wdata,
  input  logic              reg_ack,
  output logic              err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

`ifdef PANEL_AUTOREAD_EN
  typedef enum logic [1:0] {IDLE, WRITE, READ, REG} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, REG} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

  function automatic logic [3:0] low_digit(input logic [15:0] k);
    low_digit = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (k[i]) low_digit = 4'(i);
  endfunction

  function automatic logic [2:0] low_reg(input logic [4:0] k);
    low_reg = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (k[i]) low_reg = 3'(i);
  endfunction

  // All outputs are registered; err is a single-cycle strobe cleared by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      entry     <= '0;
      addr      <= '0;
      disp_data <= '0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      reg_req   <= 1'b0;
      reg_sel   <= 3'd0;
      reg_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (key_storeinc) begin
            state     <= WRITE;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= entry[DATA_W-1:0];
            tmo_cnt   <= '0;
          end else if (key_load) begin
            addr  <= entry;
            entry <= '0;
`ifdef PANEL_AUTOREAD_EN
            state    <= READ;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= entry;
            tmo_cnt  <= '0;
`endif
          end else if (key_dec) begin
            addr <= addr - ADDR_W'(1);
`ifdef PANEL_AUTOREAD_EN
            state    <= READ;
            busy     <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr - ADDR_W'(1);
            tmo_cnt  <= '0;
`endif
          end else if (|key_reg) begin
            state     <= REG;
            busy      <= 1'b1;
            reg_req   <= 1'b1;
            reg_sel   <= low_reg(key_reg);
            reg_wdata <= entry;
            tmo_cnt   <= '0;
          end else if (|key_hex) begin
            entry <= {entry[ADDR_W-5:0], low_digit(key_hex)};
          end
        end

        WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            disp_data <= mem_wdata;
            addr      <= addr + ADDR_W'(1);
            entry     <= '0;
            tmo_cnt   <= '0;
`ifdef PANEL_AUTOREAD_EN
            state <= READ;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            tmo_cnt <= CNT_W'(ACK_TIMEOUT);
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

`ifdef PANEL_AUTOREAD_EN
        // After a write the request drops for one cycle before the read request rises.
        READ: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr;
            tmo_cnt  <= '0;
          end else if (mem_ack) begin
            mem_req   <= 1'b0;
            disp_data <= mem_rdata;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            tmo_cnt <= CNT_W'(ACK_TIMEOUT);
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
`endif

        REG: begin
          if (reg_ack) begin
            reg_req <= 1'b0;
            entry   <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (tmo_hit) begin
            reg_req <= 1'b0;
            err     <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
            tmo_cnt <= CNT_W'(ACK_TIMEOUT);
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          reg_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
